// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: PC owner that fetches 1/2-byte instructions byte by byte and hands them to decode.
// Define FETCH_AHEAD_EN to start the next fetch on the same edge that an instruction is accepted.
module instr_fetch_seq #(
    parameter int ADDR_W = 13,
    parameter logic [ADDR_W-1:0] RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [15:0]       instr,
    output logic              instr_two,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);
`ifdef FETCH_AHEAD_EN
    localparam logic AHEAD = 1'b1;
`else
    localparam logic AHEAD = 1'b0;
`endif
    typedef enum logic [1:0] {FETCH0, FETCH1, HOLD} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] pc;
    logic two, accept, load0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH0;
            pc        <= RST_PC;
            instr     <= '0;
            instr_two <= 1'b0;
            instr_pc  <= '0;
        end else begin
            state <= state_nx;
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (load0) begin
                pc        <= pc + 1'b1;
                instr     <= {mem_data, 8'h00};
                instr_two <= two;
                instr_pc  <= pc;
            end else if (state == FETCH1) begin
                pc         <= pc + 1'b1;
                instr[7:0] <= mem_data;
            end
        end
    end
    // accept only occurs in HOLD; with fetch-ahead it doubles as a FETCH0 action
    always_comb begin
        two      = mem_data[7:6] == 2'b11;
        accept   = instr_valid && instr_ready;
        load0    = state == FETCH0 || (AHEAD && accept);
        state_nx = redirect_valid    ? FETCH0 :
                   load0             ? (two ? FETCH1 : HOLD) :
                   state == FETCH1   ? HOLD :
                   accept            ? FETCH0 : state;
    end
    always_comb begin
        mem_addr    = pc;
        instr_valid = state == HOLD;
    end
endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb_instr_fetch_seq: vector table plus corner-case sequences, checked through an expected-instruction queue.
module tb_instr_fetch_seq;
`ifdef FETCH_AHEAD_EN
    localparam int CYC_TP = 11;
`else
    localparam int CYC_TP = 20;
`endif
    logic        clk = 1'b0, rst = 1'b1;
    logic [12:0] mem_addr, instr_pc;
    logic [7:0]  mem_data;
    logic [15:0] instr;
    logic        instr_two, instr_valid;
    logic        instr_ready = 1'b0, redirect_valid = 1'b0;
    logic [12:0] redirect_pc = '0;
    logic [7:0]  mem [0:8191];

    typedef struct {logic [15:0] instr; logic two; logic [12:0] pc;} exp_t;
    typedef struct {logic [7:0] b0, b1; logic [15:0] exp; logic two;} vec_t;
    exp_t q[$];
    vec_t tbl[8];
    int n_chk = 0, n_pass = 0, n_acc = 0;

    assign mem_data = mem[mem_addr];
    always #5 clk = ~clk;

    instr_fetch_seq dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data(mem_data),
        .instr(instr), .instr_two(instr_two), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic push(input logic [15:0] i, input logic t, input logic [12:0] p);
        exp_t e;
        e.instr = i;
        e.two = t;
        e.pc = p;
        q.push_back(e);
    endtask

    task automatic redirect(input logic [12:0] a);
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = a;
        instr_ready = 1'b0;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_valid) fail(name);
    endtask

    task automatic drain(input string name, output int cyc);
        cyc = 0;
        while (q.size() != 0 && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        if (q.size() != 0) begin
            fail(name);
            q.delete();
        end
        #1 instr_ready = 1'b0;
    endtask

    // every accepted instruction must match the head of the queue
    always @(negedge clk) begin
        exp_t e;
        if (!rst && instr_valid && instr_ready) begin
            n_acc++;
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_instr: got %h at pc %0h, expected none", instr, instr_pc);
            end else begin
                e = q.pop_front();
                chk("instr", instr, e.instr);
                chk("instr_two", instr_two, e.two);
                chk("instr_pc", instr_pc, e.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, a, addr;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        tbl[0] = '{8'h12, 8'h34, 16'h1200, 1'b0};
        tbl[1] = '{8'hC5, 8'hA7, 16'hC5A7, 1'b1};
        tbl[2] = '{8'hBF, 8'h99, 16'hBF00, 1'b0};
        tbl[3] = '{8'h7F, 8'h01, 16'h7F00, 1'b0};
        tbl[4] = '{8'hFF, 8'h01, 16'hFF01, 1'b1};
        tbl[5] = '{8'h80, 8'hC0, 16'h8000, 1'b0};
        tbl[6] = '{8'hC0, 8'h00, 16'hC000, 1'b1};
        tbl[7] = '{8'h3C, 8'hFF, 16'h3C00, 1'b0};

        mem[0] = 8'h43; mem[1] = 8'hE8; mem[2] = 8'h96;
        instr_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_two", instr_two, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_addr", mem_addr, 0);
        push(16'h4300, 0, 0);
        push(16'hE896, 1, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("valid_before_c1", instr_valid, 0);
        @(negedge clk);
        chk("valid_at_c2", instr_valid, 1);
        drain("reset_seq", cyc);

        mem[16] = 8'hC3;
        redirect(13'h0010);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", instr_valid, 0);
        chk("midrst_instr", instr, 0);
        chk("midrst_pc", instr_pc, 0);
        chk("midrst_addr", mem_addr, 0);
        wait_valid("bp_wait");
        repeat (5) begin
            @(negedge clk);
            chk("bp_instr", instr, 16'h4300);
            chk("bp_pc", instr_pc, 0);
            chk("bp_valid", instr_valid, 1);
            chk("bp_addr", mem_addr, 1);
        end
        push(16'h4300, 0, 0);
        push(16'hE896, 1, 1);
        @(posedge clk);
        #1 instr_ready = 1'b1;
        drain("bp_seq", cyc);

        addr = 'h40;
        foreach (tbl[i]) begin
            mem[addr] = tbl[i].b0;
            if (tbl[i].two) mem[addr + 1] = tbl[i].b1;
            push(tbl[i].exp, tbl[i].two, 13'(addr));
            addr += tbl[i].two ? 2 : 1;
        end
        redirect(13'h0040);
        instr_ready = 1'b1;
        drain("table", cyc);

        mem[4] = 8'hC1; mem[5] = 8'h55; mem[32] = 8'h11;
        redirect(13'h0004);
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = 13'h0020;
        @(negedge clk);
        chk("midfetch_addr", mem_addr, 5);
        chk("midfetch_valid", instr_valid, 0);
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_valid", instr_valid, 0);
        chk("redir_addr", mem_addr, 13'h0020);
        push(16'h1100, 0, 13'h0020);
        instr_ready = 1'b1;
        drain("midfetch", cyc);

        mem[8191] = 8'hD1; mem[0] = 8'h27;
        redirect(13'h1FFF);
        wait_valid("wrap_wait");
        chk("wrap_addr", mem_addr, 1);
        push(16'hD127, 1, 13'h1FFF);
        @(posedge clk);
        #1 instr_ready = 1'b1;
        drain("wrap", cyc);

        mem[128] = 8'h05; mem[256] = 8'h0A;
        redirect(13'h0080);
        wait_valid("simul_wait");
        push(16'h0500, 0, 13'h0080);
        push(16'h0A00, 0, 13'h0100);
        a = n_acc;
        @(posedge clk);
        #1 instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 13'h0100;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk("simul_valid", instr_valid, 0);
        chk("simul_addr", mem_addr, 13'h0100);
        drain("simul", cyc);
        chk("simul_count", n_acc - a, 2);

        for (int i = 0; i < 10; i++) begin
            mem[512 + i] = 8'(i + 1);
            push(16'((i + 1) << 8), 0, 13'(512 + i));
        end
        redirect(13'h0200);
        instr_ready = 1'b1;
        drain("throughput", cyc);
        chk("throughput_cycles", cyc, CYC_TP);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/instr_fetch_seq.md
# instr_fetch_seq

Instruction fetch sequencer between the byte-wide, combinational-read instruction memory (13-bit address, 8-bit data) and the decode stage. Owns the program counter and fetches one- or two-byte instructions byte by byte. It presents each assembled instruction with a valid/ready handshake and accepts PC redirects for jumps and branches.

## Interface
- ADDR_W, 13, instruction memory address width / PC width
- RST_PC, 13'h0000, PC value loaded on reset
- clk  input  1  rising-edge clock
- rst  input  1  reset rst, synchronous, active-high
- mem_addr  output  ADDR_W  instruction memory address; always equals pc (combinational)
- mem_data  input  8  memory read data for mem_addr, valid in the same cycle
- instr  output  16  assembled instruction {byte0, byte1}; byte1 = 8'h00 for one-byte instructions
- instr_two  output  1  1 = two-byte instruction
- instr_pc  output  ADDR_W  address of byte0 of instr
- instr_valid  output  1  instr/instr_two/instr_pc valid
- instr_ready  input  1  decode stage accepts instr
- redirect_valid  input  1  load new PC
- redirect_pc  input  ADDR_W  redirect target

## Operation
- Length decode: byte0[7:6] == 2'b11 → two-byte instruction; otherwise one-byte.
- States: FETCH0, FETCH1, HOLD.
- FETCH0: capture mem_data into byte0, instr_pc <= pc, pc <= pc+1; next FETCH1 if two-byte, else HOLD with byte1 = 0.
- FETCH1: capture mem_data into byte1, pc <= pc+1; next HOLD.
- HOLD: instr_valid = 1; outputs stable until accepted. On instr_valid && instr_ready → FETCH0.
- PC arithmetic modulo 2^ADDR_W: pc 8191 + 1 = 0; a two-byte instruction at 8191 takes byte1 from address 0.
- Redirect (any state): pc <= redirect_pc, partial instruction discarded, next state FETCH0, instr_valid low the next cycle.
- Redirect and handshake in same cycle: the held instruction counts as accepted; redirect then applies (no fetch-ahead on that cycle).
- Reset: pc = RST_PC, state FETCH0, instr = 0, instr_two = 0, instr_pc = 0, instr_valid = 0. Reset overrides redirect and handshake; reset mid-instruction discards all partial state.

## Timing
- mem_addr combinational from pc; no memory latency cycles.
- All other outputs registered.
- Baseline latency from FETCH0 entry to instr_valid: 1 cycle (one-byte), 2 cycles (two-byte).
- Baseline throughput with instr_ready held high: one-byte instruction every 2 cycles; two-byte every 3 cycles.
- First instr_valid after rst deasserts: cycle 2 (one-byte) or cycle 3 (two-byte), counting the first non-reset edge as cycle 1.
- instr_ready while instr_valid = 0 is ignored.

## Configuration
- FETCH_AHEAD_EN defined: in HOLD, on instr_valid && instr_ready without redirect, the unit performs the FETCH0 action on the same edge (mem_addr already equals pc), going directly to HOLD (one-byte) or FETCH1 (two-byte). Throughput: 1 cycle per one-byte instruction, 2 cycles per two-byte instruction; instr_valid stays high across back-to-back one-byte instructions.
- FETCH_AHEAD_EN undefined: baseline behaviour above; HOLD always returns to FETCH0.

## Test plan
- Reset: memory {0:8'h43, 1:8'hE8, 2:8'h96}, instr_ready = 1 → instr_valid low during rst; first instr = 16'h4300, instr_two = 0, instr_pc = 0; then 16'hE896, instr_two = 1, instr_pc = 1.
- Backpressure: instr_ready = 0 for 5 cycles with instr 16'h4300 held → outputs stable, pc stays 1, mem_addr = 1; ready high → one acceptance, next instr_pc = 1.
- Redirect mid-fetch: redirect_valid with redirect_pc = 13'h0020 in FETCH1 of two-byte at address 4 → byte1 discarded, next instr_pc = 0x20, no instruction from address 4 delivered.
- Wrap: redirect to 8191, memory[8191] = 8'hD1, memory[0] = 8'h27 → instr = 16'hD127, instr_pc = 8191, pc = 1 afterwards.
- Simultaneous: instr_valid && instr_ready && redirect_valid (pc 0x100) → instruction counted once, next instr_pc = 0x100.
- Throughput: ten one-byte instructions, ready high → 20 cycles baseline; 10 cycles + initial latency with FETCH_AHEAD_EN.
